// File: rtl/uart_host_rx_pkg.sv
// Shared constants and FSM state type for the uart_host_rx receiver.
// The StParity state exists only when UART_HOST_RX_PARITY_EN is defined.
package uart_host_rx_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_HOST_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

endpackage

// File: rtl/uart_host_rx_fifo.sv
// Receive FIFO with extra-bit pointers; a push into a full FIFO is accepted only alongside a pop.
// rdata reads as zero while the FIFO is empty.
module uart_host_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_host_rx.sv
// Host-side UART receiver: synchronised rx line, 8-bit frame FSM, receive FIFO.
// Define UART_HOST_RX_PARITY_EN for an even parity bit and the parity_err_o port.
module uart_host_rx
  import uart_host_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
`ifdef UART_HOST_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] BitOne  = BitW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   hold_q, hold_d;
  logic                   discard_q, discard_d;
  logic                   cnt_zero, push, frame_err;
  logic                   fifo_full, fifo_empty, pop;
`ifdef UART_HOST_RX_PARITY_EN
  logic                   parity_err;
`endif

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      hold_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = StStart;
          cnt_d     = CntHalf;
          discard_d = 1'b0;
        end
      end
      StStart: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntOne;
        end else if (!rx_s) begin
          state_d = StData;
          cnt_d   = CntFull;
          bit_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CntFull;
          bit_d   = bit_q + BitOne;
`ifdef UART_HOST_RX_PARITY_EN
          if (bit_q == LastBit) state_d = StParity;
`else
          if (bit_q == LastBit) state_d = StStop;
`endif
        end
      end
`ifdef UART_HOST_RX_PARITY_EN
      StParity: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          discard_d = (rx_s != ^shift_q);
          state_d   = StStop;
          cnt_d     = CntFull;
        end
      end
`endif
      StStop: begin
        // After a low stop bit, wait for the line to go idle before accepting a new start.
        if (hold_q) begin
          if (rx_s) begin
            state_d = StIdle;
            hold_d  = 1'b0;
          end
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CntOne;
        end else if (rx_s) begin
          state_d = StIdle;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
    if (state_q == StStop && !hold_q && cnt_zero) begin
      push      = rx_s && !discard_q;
      frame_err = !rx_s;
    end
`ifdef UART_HOST_RX_PARITY_EN
    parity_err = (state_q == StParity) && cnt_zero && (rx_s != ^shift_q);
`endif
  end

  uart_host_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .wdata(shift_q),
    .full (fifo_full),
    .pop  (pop),
    .rdata(rdata_o),
    .empty(fifo_empty)
  );

  assign rvalid_o    = !fifo_empty;
  assign pop         = rvalid_o && rready_i;
  assign overflow_o  = push && fifo_full && !pop;
  assign frame_err_o = frame_err;
  assign busy_o      = (state_q != StIdle);
`ifdef UART_HOST_RX_PARITY_EN
  assign parity_err_o = parity_err;
`endif

endmodule

// File: tb/tb_uart_host_rx.sv
// Self-checking bench for uart_host_rx: vector table, corner-case sequences, random frames.
// Honours UART_HOST_RX_PARITY_EN to exercise the parity build.
module tb_uart_host_rx;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned DEPTH   = 4;
`ifdef UART_HOST_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, rready;
  logic [7:0] rdata;
  logic       rvalid, frame_err, overflow, busy;
`ifdef UART_HOST_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_host_rx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
`ifdef UART_HOST_RX_PARITY_EN
    .parity_err_o(parity_err),
`endif
    .busy_o      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_t0 = 0;

  // Observation state gathered at the falling edge.
  logic [7:0] got_q[$];
  int   n_ferr = 0, n_ovf = 0, n_perr = 0;
  int   first_valid = -1, ovf_cyc = -1;
  logic rvalid_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rvalid && rready) got_q.push_back(rdata);
    if (frame_err) n_ferr++;
    if (overflow) begin
      n_ovf++;
      ovf_cyc = cyc;
    end
`ifdef UART_HOST_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    if (rvalid && !rvalid_prev && first_valid < 0) first_valid = cyc;
    rvalid_prev = rvalid;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    n_ferr = 0;
    n_ovf = 0;
    n_perr = 0;
    first_valid = -1;
    ovf_cyc = -1;
  endtask

  // Called just after a rising edge; leaves the line idle high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    last_t0 = cyc;
    rx = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CLK_DIV);
    end
`ifdef UART_HOST_RX_PARITY_EN
    rx = (^d) ^ !par_ok;
    tick(CLK_DIV);
`endif
    rx = stop_ok;
    tick(CLK_DIV);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    bit         exp_push;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];
  int   exp_ferr_total;
  bit   rand_done;

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1, 0});
    vecs.push_back('{8'h55, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 0, 0});
`ifdef UART_HOST_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 0, 1});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 0, 0});
`endif

    // Reset state
    rst = 1'b1;
    rx = 1'b1;
    rready = 1'b0;
    tick(3);
    check("reset rvalid", rvalid, 0);
    check("reset rdata", rdata, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overflow", overflow, 0);
    rst = 1'b0;
    tick(4);

    // Latency from stop-bit centre to rvalid
    clear_obs();
    rready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(CLK_DIV);
    check("latency rvalid cycle", first_valid,
          last_t0 + (NBITS - 1) * CLK_DIV + CLK_DIV / 2 + 3);
    check("latency data count", got_q.size(), 1);
    if (got_q.size() > 0) check("latency data", got_q[0], 8'hA5);
    check("latency frame_err", n_ferr, 0);

    // Vector table
    foreach (vecs[k]) begin
      clear_obs();
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].par_ok);
      tick(2 * CLK_DIV);
      check($sformatf("vec%0d pushes", k), got_q.size(), int'(vecs[k].exp_push));
      if (vecs[k].exp_push && got_q.size() > 0)
        check($sformatf("vec%0d data", k), got_q[0], vecs[k].data);
      check($sformatf("vec%0d frame_err", k), n_ferr, vecs[k].exp_ferr);
      check($sformatf("vec%0d parity_err", k), n_perr, vecs[k].exp_perr);
      check($sformatf("vec%0d busy", k), busy, 0);
    end

    // 5-cycle glitch
    clear_obs();
    rx = 1'b0;
    tick(4);
    check("glitch busy rises", busy, 1);
    tick(1);
    rx = 1'b1;
    tick(8);
    check("glitch busy clears", busy, 0);
    tick(2 * CLK_DIV);
    check("glitch pushes", got_q.size(), 0);
    check("glitch frame_err", n_ferr, 0);

    // Overflow: five frames into a depth-4 FIFO
    clear_obs();
    rready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    tick(2 * CLK_DIV);
    check("overflow pulses", n_ovf, 1);
    check("overflow on byte 5", int'(ovf_cyc > last_t0), 1);
    check("overflow rvalid held", rvalid, 1);
    rready = 1'b1;
    tick(6);
    rready = 1'b0;
    check("overflow pop count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("overflow pop %0d", i), got_q[i], i + 1);
    check("overflow drained", rvalid, 0);

    // Reset in the middle of a frame's data bits
    clear_obs();
    send_frame(8'h11, 1'b1, 1'b1);
    tick(4);
    check("pre-reset rvalid", rvalid, 1);
    rx = 1'b0;
    tick(CLK_DIV);
    rx = 1'b1;
    tick(2 * CLK_DIV);
    check("mid-frame busy", busy, 1);
    rst = 1'b1;
    tick(1);
    check("mid reset rvalid", rvalid, 0);
    check("mid reset rdata", rdata, 0);
    check("mid reset busy", busy, 0);
    check("mid reset errs", int'(frame_err) + int'(overflow), 0);
    rst = 1'b0;
    tick(3 * CLK_DIV);
    check("post reset idle", busy, 0);
    rready = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b1);
    tick(2 * CLK_DIV);
    check("post reset count", got_q.size(), 1);
    if (got_q.size() > 0) check("post reset data", got_q[0], 8'hFF);
    check("post reset frame_err", n_ferr, 0);

    // Random frames against a queue model; some carry a low stop bit
    clear_obs();
    exp_q.delete();
    exp_ferr_total = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] d;
          bit good;
          d = 8'($urandom);
          good = ($urandom_range(0, 5) != 0);
          send_frame(d, good, 1'b1);
          if (good) exp_q.push_back(d);
          else exp_ferr_total++;
          tick(good ? $urandom_range(0, 40) : CLK_DIV + $urandom_range(0, 40));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    rready = 1'b1;
    tick(2 * CLK_DIV);
    check("random count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("random byte %0d", i), got_q[i], exp_q[i]);
    check("random frame_err", n_ferr, exp_ferr_total);
    check("random overflow", n_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
